// File: rtl/dvp_grey_conv.sv
// dvp_grey_conv: assembles RGB565/RGB888 pixels from camera bytes and emits one grey sample per pixel
// Ports: clk_i/rst_n_i clock and async active-low reset; mode_i/thr_i conversion select and threshold,
// latched while in_vsync_i is high; in_* camera byte stream; out_* grey sample with sof/eol markers;
// line_err_o pulses when a line ends with the wrong pixel count or a partial pixel.
module dvp_grey_conv #(
   parameter int BYTES_PER_PIX = 2,
   parameter int OUT_W         = 8,
   parameter int H_ACTIVE      = 1280
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [1:0]       mode_i,
   input  logic [7:0]       thr_i,
   input  logic             in_vsync_i,
   input  logic             in_href_i,
   input  logic             in_valid_i,
   input  logic [7:0]       in_data_i,
   output logic             out_valid_o,
   output logic [OUT_W-1:0] out_grey_o,
   output logic             out_sof_o,
   output logic             out_eol_o,
   output logic             line_err_o
);
   // one spare counter bit so an overlong line saturates well clear of the eol/line-length values
   localparam int            CW       = $clog2(H_ACTIVE + 1) + 1;
   localparam logic [1:0]    LAST     = 2'(BYTES_PER_PIX - 1);
   localparam logic [CW-1:0] EOL_CNT  = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] LINE_CNT = CW'(H_ACTIVE);
   logic          w_acc, w_done, w_fall, w_bad;
   logic [1:0]    w_ph;
   logic [4:0]    w_r5, w_b5;
   logic [5:0]    w_g6;
   logic [7:0]    w_r8, w_g8, w_b8;
   logic [9:0]    w_sum3;
   logic [15:0]   w_ysum;
   logic [16:0]   w_msum;
   logic [7:0]    w_y, w_mean, w_res;
   logic [1:0]    r_phase;
   logic [CW-1:0] r_cnt;
   logic          r_sof_pend, r_href_d1, r_href_d2, r_vs_d;
   logic [1:0]    r_mode;
   logic [7:0]    r_thr, r_b0, r_b1;
   logic          r_s1_v, r_s1_sof, r_s1_eol;
   logic [7:0]    r_s1_r, r_s1_g, r_s1_b, r_s1_thr;
   logic [1:0]    r_s1_mode;
   logic          r_s2_v, r_s2_sof, r_s2_eol;
   logic [15:0]   r_s2_pr, r_s2_pg, r_s2_pb;
   logic [16:0]   r_s2_mp;
   logic [7:0]    r_s2_g, r_s2_thr;
   logic [1:0]    r_s2_mode;
   assign w_acc  = in_valid_i && in_href_i && !in_vsync_i;
   // line end seen one cycle late via two href registers, so line_err_o lands 2 cycles after href drops
   assign w_fall = r_href_d2 && !r_href_d1;
   assign w_bad  = (r_cnt != LINE_CNT) || (r_phase != 2'd0);
   // a byte arriving on the line-end cycle starts a fresh pixel, not the discarded partial one
   assign w_ph   = w_fall ? 2'd0 : r_phase;
   assign w_done = w_acc && (w_ph == LAST);
   assign w_r5   = r_b0[7:3];
   assign w_g6   = {r_b0[2:0], in_data_i[7:5]};
   assign w_b5   = in_data_i[4:0];
   assign w_r8   = (BYTES_PER_PIX == 3) ? r_b0      : {w_r5, w_r5[4:2]};
   assign w_g8   = (BYTES_PER_PIX == 3) ? r_b1      : {w_g6, w_g6[5:4]};
   assign w_b8   = (BYTES_PER_PIX == 3) ? in_data_i : {w_b5, w_b5[4:2]};
   assign w_sum3 = 10'(r_s1_r) + 10'(r_s1_g) + 10'(r_s1_b);
   assign w_ysum = r_s2_pr + r_s2_pg + r_s2_pb + 16'd128;
   assign w_msum = r_s2_mp + 17'd256;
   assign w_y    = 8'(w_ysum >> 8);
   assign w_mean = 8'(w_msum >> 9);
   assign w_res  = (r_s2_mode == 2'd0) ? w_y :
                   (r_s2_mode == 2'd1) ? w_mean :
                   (r_s2_mode == 2'd2) ? r_s2_g :
                   ((w_y >= r_s2_thr) ? 8'hFF : 8'h00);
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_phase    <= 2'd0;
         r_cnt      <= '0;
         r_sof_pend <= 1'b1;
         r_mode     <= 2'd0;
         r_thr      <= 8'd0;
         r_href_d1  <= 1'b0;
         r_href_d2  <= 1'b0;
         r_vs_d     <= 1'b0;
         r_b0       <= 8'd0;
         r_b1       <= 8'd0;
         line_err_o <= 1'b0;
      end else begin
         r_href_d1  <= in_href_i;
         r_href_d2  <= r_href_d1;
         r_vs_d     <= in_vsync_i;
         line_err_o <= w_fall && w_bad && !in_vsync_i && !r_vs_d;
         if (w_acc && w_ph == 2'd0) r_b0 <= in_data_i;
         if (w_acc && w_ph == 2'd1) r_b1 <= in_data_i;
         if (in_vsync_i) begin
            r_phase    <= 2'd0;
            r_cnt      <= '0;
            r_sof_pend <= 1'b1;
            r_mode     <= mode_i;
            r_thr      <= thr_i;
         end else begin
            if (w_acc) r_phase <= w_done ? 2'd0 : w_ph + 2'd1;
            else if (w_fall) r_phase <= 2'd0;
            if (w_fall) r_cnt <= '0;
            else if (w_done) r_cnt <= (&r_cnt) ? r_cnt : r_cnt + CW'(1);
            if (w_done) r_sof_pend <= 1'b0;
         end
      end
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_s1_v      <= 1'b0;
         r_s1_sof    <= 1'b0;
         r_s1_eol    <= 1'b0;
         r_s1_r      <= 8'd0;
         r_s1_g      <= 8'd0;
         r_s1_b      <= 8'd0;
         r_s1_thr    <= 8'd0;
         r_s1_mode   <= 2'd0;
         r_s2_v      <= 1'b0;
         r_s2_sof    <= 1'b0;
         r_s2_eol    <= 1'b0;
         r_s2_pr     <= 16'd0;
         r_s2_pg     <= 16'd0;
         r_s2_pb     <= 16'd0;
         r_s2_mp     <= 17'd0;
         r_s2_g      <= 8'd0;
         r_s2_thr    <= 8'd0;
         r_s2_mode   <= 2'd0;
         out_valid_o <= 1'b0;
         out_grey_o  <= '0;
         out_sof_o   <= 1'b0;
         out_eol_o   <= 1'b0;
      end else begin
         r_s1_v <= w_done;
         if (w_done) begin
            r_s1_r    <= w_r8;
            r_s1_g    <= w_g8;
            r_s1_b    <= w_b8;
            r_s1_sof  <= r_sof_pend;
            r_s1_eol  <= (r_cnt == EOL_CNT);
            r_s1_mode <= r_mode;
            r_s1_thr  <= r_thr;
         end
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_pr   <= 16'(r_s1_r) * 16'd77;
            r_s2_pg   <= 16'(r_s1_g) * 16'd150;
            r_s2_pb   <= 16'(r_s1_b) * 16'd29;
            r_s2_mp   <= 17'(w_sum3) * 17'd171;
            r_s2_g    <= r_s1_g;
            r_s2_sof  <= r_s1_sof;
            r_s2_eol  <= r_s1_eol;
            r_s2_mode <= r_s1_mode;
            r_s2_thr  <= r_s1_thr;
         end
         out_valid_o <= r_s2_v;
         out_sof_o   <= r_s2_v && r_s2_sof;
         out_eol_o   <= r_s2_v && r_s2_eol;
         if (r_s2_v) out_grey_o <= OUT_W'(w_res >> (8 - OUT_W));
      end
   end
endmodule

// File: tb/tb_dvp_grey_conv.sv
// tb_dvp_grey_conv: two instances (RGB565/8-bit and RGB888/4-bit, 4-pixel lines) fed one shared byte stream
module tb_dvp_grey_conv;
   localparam int H = 4;
   typedef struct {
      int   k;
      int   kind;
      int   cyc;
      int   g;
      logic sof;
      logic eol;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] mode_i = 2'd0;
   logic [7:0] thr_i = 8'd0;
   logic       vs = 1'b0, hr = 1'b0, vl = 1'b0;
   logic [7:0] din = 8'd0;
   logic       ov0, sof0, eol0, le0, ov1, sof1, eol1, le1;
   logic [7:0] og0;
   logic [3:0] og1;
   int         cyc = 0;
   int         n_cmp = 0, n_fail = 0;
   exp_t       eq[$];
   int         fmode = 0, fthr = 0;
   bit         sofp[2] = '{1'b1, 1'b1};
   logic       mv, ms, me, ml;
   logic [7:0] mg;
   int         mip, mie;
   bit         mxv, mxe;
   logic [7:0] q[$], luma[$], red[$];
   dvp_grey_conv #(.BYTES_PER_PIX(2), .OUT_W(8), .H_ACTIVE(H)) u0 (
      .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode_i), .thr_i(thr_i),
      .in_vsync_i(vs), .in_href_i(hr), .in_valid_i(vl), .in_data_i(din),
      .out_valid_o(ov0), .out_grey_o(og0), .out_sof_o(sof0), .out_eol_o(eol0), .line_err_o(le0));
   dvp_grey_conv #(.BYTES_PER_PIX(3), .OUT_W(4), .H_ACTIVE(H)) u1 (
      .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode_i), .thr_i(thr_i),
      .in_vsync_i(vs), .in_href_i(hr), .in_valid_i(vl), .in_data_i(din),
      .out_valid_o(ov1), .out_grey_o(og1), .out_sof_o(sof1), .out_eol_o(eol1), .line_err_o(le1));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic int find(input int k, input int kind);
      for (int i = 0; i < eq.size(); i++) if (eq[i].k == k && eq[i].kind == kind) return i;
      return -1;
   endfunction
   // reference conversion straight from the channel/arithmetic rules
   function automatic int grey(input int bpp, input int ow, input int m, input int t,
                               input int x0, input int x1, input int x2);
      int r, g, b, g6, y, v;
      if (bpp == 2) begin
         r  = (x0 >> 3) * 8 + (x0 >> 3) / 4;
         g6 = ((x0 & 7) << 3) | (x1 >> 5);
         g  = g6 * 4 + g6 / 16;
         b  = (x1 & 31) * 8 + (x1 & 31) / 4;
      end else begin
         r = x0; g = x1; b = x2;
      end
      y = (77 * r + 150 * g + 29 * b + 128) / 256;
      v = (m == 0) ? y : (m == 1) ? ((r + g + b) * 171 + 256) / 512 : (m == 2) ? g : ((y >= t) ? 255 : 0);
      return v >> (8 - ow);
   endfunction
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            mv = k ? ov1 : ov0;
            ms = k ? sof1 : sof0;
            me = k ? eol1 : eol0;
            ml = k ? le1 : le0;
            mg = k ? {4'd0, og1} : og0;
            mip = find(k, 0);
            mxv = (mip >= 0) && (eq[mip].cyc == cyc);
            if (mv || mxv) chk($sformatf("valid%0d@%0d", k, cyc), 32'(mv), 32'(mxv));
            if (mv && mxv) begin
               chk($sformatf("grey%0d@%0d", k, cyc), 32'(mg), 32'(eq[mip].g));
               chk($sformatf("sof%0d@%0d", k, cyc), 32'(ms), 32'(eq[mip].sof));
               chk($sformatf("eol%0d@%0d", k, cyc), 32'(me), 32'(eq[mip].eol));
            end
            if (mxv) eq.delete(mip);
            mie = find(k, 1);
            mxe = (mie >= 0) && (eq[mie].cyc == cyc);
            if (ml || mxe) chk($sformatf("line_err%0d@%0d", k, cyc), 32'(ml), 32'(mxe));
            if (mxe) eq.delete(mie);
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         step();
         vl  = 1'($urandom);
         din = 8'($urandom);
      end
   endtask
   task automatic vsync(input int m, input int t);
      step();
      hr = 1'b0; vs = 1'b1; mode_i = 2'(m); thr_i = 8'(t);
      repeat (3) step();
      vs = 1'b0;
      fmode = m; fthr = t;
      sofp = '{1'b1, 1'b1};
   endtask
   task automatic line(input logic [7:0] b[$], input int gap);
      int   bpp, pi;
      exp_t x;
      step();
      hr = 1'b1; vl = 1'b0;
      foreach (b[j]) begin
         while ($urandom_range(99) < gap) begin
            step();
            vl = 1'b0; din = 8'($urandom);
         end
         step();
         vl = 1'b1; din = b[j];
         for (int k = 0; k < 2; k++) begin
            bpp = k ? 3 : 2;
            if ((j + 1) % bpp == 0) begin
               pi    = (j + 1) / bpp - 1;
               x.k   = k; x.kind = 0; x.cyc = cyc + 3;
               x.g   = grey(bpp, k ? 4 : 8, fmode, fthr, int'(b[j - bpp + 1]), int'(b[j - bpp + 2]),
                            bpp == 3 ? int'(b[j]) : 0);
               x.sof = sofp[k];
               x.eol = (pi == H - 1);
               sofp[k] = 1'b0;
               eq.push_back(x);
            end
         end
      end
      step();
      vl = 1'b0; hr = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bpp = k ? 3 : 2;
         if (b.size() / bpp != H || b.size() % bpp != 0) begin
            x.k = k; x.kind = 1; x.cyc = cyc + 2; x.g = 0; x.sof = 1'b0; x.eol = 1'b0;
            eq.push_back(x);
         end
      end
      idle(4);
   endtask
   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      luma = {8'hFF, 8'hFF, 8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
      red  = {8'hF8, 8'h00, 8'hF8, 8'h00, 8'hF8, 8'h00, 8'hF8, 8'h00};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid0", 32'(ov0), 0);
      chk("rst_grey0", 32'(og0), 0);
      chk("rst_sof0", 32'(sof0), 0);
      chk("rst_eol0", 32'(eol0), 0);
      chk("rst_err0", 32'(le0), 0);
      chk("rst_valid1", 32'(ov1), 0);
      chk("rst_grey1", 32'(og1), 0);
      chk("rst_err1", 32'(le1), 0);
      rst_n = 1'b1;
      idle(2);
      vsync(0, 0);
      line(luma, 0);
      vsync(1, 0);
      line(red, 0);
      vsync(2, 0);
      line(red, 0);
      vsync(3, 100);
      q = {8'hF8, 8'h00, 8'h07, 8'hE0, 8'hF8, 8'h00, 8'h07, 8'hE0};
      line(q, 0);
      vsync(0, 0);
      line(luma, 0);
      mode_i = 2'd2; thr_i = 8'd200;
      line(luma, 20);
      vsync(2, 0);
      line(luma, 0);
      vsync(0, 0);
      q = {8'hFF, 8'hFF, 8'hF8, 8'h00, 8'h07, 8'hE0};
      line(q, 0);
      q = {8'hFF, 8'hFF, 8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'h55};
      line(q, 0);
      line(luma, 0);
      q.delete();
      repeat (12) q.push_back(8'h80);
      line(q, 0);
      repeat (4) begin
         vsync($urandom_range(3), $urandom_range(255));
         repeat (3) begin
            q.delete();
            repeat ($urandom_range(14)) q.push_back(8'($urandom));
            mode_i = 2'($urandom);
            line(q, 30);
         end
      end
      step();
      hr = 1'b1; vl = 1'b0;
      repeat (4) begin
         step();
         vl = 1'b1; din = 8'($urandom);
      end
      step();
      vl = 1'b0; hr = 1'b0;
      #1 rst_n = 1'b0;
      eq.delete();
      #1;
      chk("midrst_valid0", 32'(ov0), 0);
      chk("midrst_valid1", 32'(ov1), 0);
      chk("midrst_sof0", 32'(sof0), 0);
      chk("midrst_grey0", 32'(og0), 0);
      repeat (3) step();
      rst_n = 1'b1;
      fmode = 0; fthr = 0;
      sofp = '{1'b1, 1'b1};
      mode_i = 2'd3; thr_i = 8'd255;
      idle(5);
      line(luma, 0);
      idle(6);
      chk("drained", 32'(eq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/dvp_grey_conv.md
# dvp_grey_conv

Streaming colour-to-grey converter sitting between the DVP capture path and the video generator. Accepts camera bytes already synchronised into the system clock domain, assembles RGB565 or RGB888 pixels, and emits one grey sample per pixel. The grey sample is BT.601 luma, channel mean, green-only or a binary threshold. Also tracks frame/line structure and flags malformed lines.

## Interface
- BYTES_PER_PIX, 2: 2 = RGB565, big-endian (byte0 = R[4:0]G[5:3], byte1 = G[2:0]B[4:0]); 3 = RGB888, byte order R,G,B. Other values are illegal.
- OUT_W, 8: grey output width, 1..8. The output is the top OUT_W bits of the internal 8-bit result.
- H_ACTIVE, 1280: expected pixels per line.
- clk_i  in  1  system clock; all logic is in this single domain.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- mode_i  in  2  00 = BT.601 luma, 01 = mean, 10 = green, 11 = threshold.
- thr_i  in  8  threshold for mode 11.
- in_vsync_i  in  1  frame sync, active-high.
- in_href_i  in  1  line-active qualifier.
- in_valid_i  in  1  byte strobe. A byte is accepted when in_valid_i && in_href_i && !in_vsync_i.
- in_data_i  in  8  camera byte.
- out_valid_o  out  1  grey sample valid.
- out_grey_o  out  OUT_W  grey sample.
- out_sof_o  out  1  qualifies the first pixel of a frame.
- out_eol_o  out  1  qualifies pixel index H_ACTIVE-1 of a line.
- line_err_o  out  1  one-cycle error pulse.

## Operation
- Byte phase counter, 0..BYTES_PER_PIX-1.
  - Increments on each accepted byte and wraps to 0 after the last byte of a pixel.
  - A pixel completes on the accepted byte with phase = BYTES_PER_PIX-1.
- While in_vsync_i = 1:
  - byte phase and pixel counter are cleared;
  - sof_pending is set;
  - mode_i and thr_i are latched every cycle. The last value before vsync falls governs the whole frame; mode changes mid-frame are ignored.
- Channel expansion to 8 bits:
  - RGB565: R8 = {R5, R5[4:2]}, G8 = {G6, G6[5:4]}, B8 = {B5, B5[4:2]}.
  - RGB888: used as-is.
- Conversion (all unsigned, no overflow, results 0..255):
  - Y601 = (77·R + 150·G + 29·B + 128) >> 8.
  - Mean = ((R+G+B)·171 + 256) >> 9.
  - Green = G8.
  - Threshold = (Y601 >= thr) ? 8'hFF : 8'h00.
- out_grey_o = result[7:8-OUT_W].
- out_sof_o is high on the first pixel completed after sof_pending is set; that pixel clears sof_pending.
- Pixel counter:
  - increments per completed pixel;
  - out_eol_o accompanies the pixel with count = H_ACTIVE-1;
  - pixels beyond H_ACTIVE are still output, with no eol.
- Line end is the in_href_i falling edge, detected with a registered copy of href.
  - If the pixel count ≠ H_ACTIVE, or the byte phase ≠ 0 (partial pixel), line_err_o pulses.
  - Either way the counter and phase are cleared; a partial pixel is discarded.
- A line end coinciding with vsync produces no error pulse.

## Timing
- Three-stage pipeline:
  - S1: pixel assembled and channels expanded.
  - S2: products formed.
  - S3: sum, shift, mode mux.
- The completing byte accepted at cycle N gives out_valid_o at N+3.
- Throughput is one byte per cycle: a pixel every BYTES_PER_PIX cycles.
- sof/eol travel with their pixel through the pipeline.
- line_err_o asserts the cycle after the registered href falls: 2 cycles after in_href_i goes low. It is independent of pipeline contents.
- Reset values: all outputs 0; pipeline valid bits 0; phase 0; counter 0; sof_pending 1; latched mode 00; latched thr 0.
- Reset asserted mid-pixel or mid-pipeline:
  - all in-flight data is dropped and outputs are 0 immediately (asynchronous);
  - after release, the first pixel is flagged sof.
- No back-pressure; the downstream side must accept every out_valid_o cycle.

## Test plan
- **Luma, RGB565, OUT_W = 8:** mode 00; after a vsync pulse, one line of bytes FF,FF / F8,00 / 07,E0 / 00,1F -> grey 255, 77, 149, 29. out_sof_o on the first pixel; each output 3 cycles after its second byte.
- **Modes on pure red (F8,00):** mean (01) -> 85; green (10) -> 0. Threshold (11, thr = 100): red -> 0, pure green -> 255.
- **Mode latching:** mode_i changed from 00 to 10 mid-frame -> outputs stay luma until the next vsync, then green.
- **Line errors, H_ACTIVE = 4:**
  - 4 pixels -> eol on the 4th, no error.
  - 3 pixels -> no eol; line_err_o pulses once, 2 cycles after href falls.
  - 4 pixels plus 1 odd byte -> eol on the 4th, line_err_o pulses, the partial pixel is discarded and the next line starts at phase 0.
- **RGB888 with OUT_W = 4:** BYTES_PER_PIX = 3; bytes 80,80,80 -> Y601 = 128, out_grey_o = 4'h8. Back-to-back valid gives one pixel every 3 cycles.
- **Reset mid-stream:** rst_n_i pulsed low with 2 pixels in the pipeline -> out_valid_o = 0 at once, nothing emitted after release. The next pixel after release carries out_sof_o = 1.
